// File: rtl/buffer_wide_to_narrow.sv
// Wide-to-narrow FIFO: stores up to DEPTH wide words with a per-entry slice count
// and presents them OUT_W bits at a time, lowest slice first, as a fall-through read port.
module buffer_wide_to_narrow #(
    parameter  int IN_W  = 512,
    parameter  int OUT_W = 64,
    parameter  int DEPTH = 4,
    localparam int RATIO = IN_W / OUT_W,
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1,
    localparam int CW    = $clog2(DEPTH * RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [IN_W-1:0]  data_in,
    input  logic [LW-1:0]    wr_len,
    input  logic             wr_enable,
    output logic [OUT_W-1:0] data_out,
    input  logic             rd_enable,
    output logic             last,
    output logic             full,
    output logic             full_n,
    output logic             empty,
    output logic [CW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [IN_W-1:0] mem_data [DEPTH];
    logic [LW-1:0]   mem_len  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic [LW-1:0] sub_idx;
    logic [CW-1:0] level_q;
    logic          overflow_q;
    logic          underflow_q;

    logic wr_acc;
    logic rd_acc;
    logic head_done;
    logic rd_retire;

    // Handshake: a write transfers on the rising edge when wr_enable && full_n,
    // a read transfers when rd_enable && !empty; both are judged on pre-edge state.
    assign full      = (count == NW'(DEPTH));
    assign full_n    = !full;
    assign empty     = (count == '0);
    assign wr_acc    = wr_enable && !full;
    assign rd_acc    = rd_enable && !empty;
    assign head_done = (sub_idx == mem_len[rd_ptr]);
    assign rd_retire = rd_acc && head_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sub_idx     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sub_idx     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                if (head_done) begin
                    sub_idx <= '0;
                    rd_ptr  <= rd_ptr + PW'(1);
                end else begin
                    sub_idx <= sub_idx + LW'(1);
                end
            end
            count   <= count + NW'(wr_acc) - NW'(rd_retire);
            level_q <= level_q + (wr_acc ? (CW'(wr_len) + CW'(1)) : CW'(0)) - CW'(rd_acc);
            if (wr_enable && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_enable && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem_data[wr_ptr] <= data_in;
            mem_len[wr_ptr]  <= wr_len;
        end
    end

    always_comb begin
        data_out = '0;
        if (!empty) begin
            for (int k = 0; k < RATIO; k++) begin
                if (LW'(k) == sub_idx) begin
                    data_out = mem_data[rd_ptr][k*OUT_W +: OUT_W];
                end
            end
        end
    end

    assign last      = !empty && head_done;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_buffer_wide_to_narrow.sv
// Directed bench for buffer_wide_to_narrow: fill/drain, partial entries, full/overflow,
// concurrent access, clr and asynchronous reset.
module tb_buffer_wide_to_narrow;

    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int DEPTH = 4;
    localparam int RATIO = IN_W / OUT_W;
    localparam int LW    = 3;
    localparam int CW    = 6;
    localparam int SW    = OUT_W + CW + 6;

    // {data_out, last, full, full_n, empty, level, overflow, underflow}
    localparam logic [SW-1:0] RESET_STATUS =
        {{OUT_W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1, {CW{1'b0}}, 1'b0, 1'b0};

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic [IN_W-1:0]  data_in;
    logic [LW-1:0]    wr_len;
    logic             wr_enable;
    logic [OUT_W-1:0] data_out;
    logic             rd_enable;
    logic             last;
    logic             full;
    logic             full_n;
    logic             empty;
    logic [CW-1:0]    level;
    logic             overflow;
    logic             underflow;
    logic [SW-1:0]    status;

    int n_checks = 0;
    int n_pass   = 0;

    assign status = {data_out, last, full, full_n, empty, level, overflow, underflow};

    buffer_wide_to_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .data_in   (data_in),
        .wr_len    (wr_len),
        .wr_enable (wr_enable),
        .data_out  (data_out),
        .rd_enable (rd_enable),
        .last      (last),
        .full      (full),
        .full_n    (full_n),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // slice k = base+k for k < n, recognisable filler above that
    function automatic logic [IN_W-1:0] make_word(input int base, input int n);
        logic [IN_W-1:0] w;
        w = '0;
        for (int k = 0; k < RATIO; k++) begin
            w[k*OUT_W +: OUT_W] = (k < n) ? OUT_W'(base + k) : OUT_W'(32'hdead_0000 + k);
        end
        return w;
    endfunction

    task automatic do_write(input logic [IN_W-1:0] d, input int len);
        @(negedge clk);
        data_in   = d;
        wr_len    = LW'(len);
        wr_enable = 1'b1;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (status !== RESET_STATUS) $display("FAIL reset_async: got %h exp %h", status, RESET_STATUS);
        else n_pass++;
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (status !== RESET_STATUS) $display("FAIL reset_release: got %h exp %h", status, RESET_STATUS);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        do_write(make_word(1, 8), 7);
        do_write(make_word(9, 8), 7);
        do_write(make_word(17, 8), 7);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            n_checks++;
            if ({data_out, last, level} !== {OUT_W'(i), 1'((i % 8) == 0), CW'(25 - i)})
                $display("FAIL fill_drain[%0d]: data=%0d last=%0b level=%0d exp data=%0d last=%0b level=%0d",
                         i, data_out, last, level, i, (i % 8) == 0, 25 - i);
            else n_pass++;
            rd_enable = 1'b1;
        end
        @(negedge clk);
        rd_enable = 1'b0;
        n_checks++;
        if ({empty, level, last, data_out} !== {1'b1, CW'(0), 1'b0, OUT_W'(0)})
            $display("FAIL fill_drain_empty: empty=%0b level=%0d last=%0b data=%0d exp 1 0 0 0",
                     empty, level, last, data_out);
        else n_pass++;
    endtask

    task automatic test_partial();
        do_write(make_word(1, 3), 2);
        do_write(make_word(4, 8), 7);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            n_checks++;
            if ({data_out, last, level} !== {OUT_W'(i), 1'(i == 3 || i == 11), CW'(12 - i)})
                $display("FAIL partial[%0d]: data=%0d last=%0b level=%0d exp data=%0d last=%0b level=%0d",
                         i, data_out, last, level, i, (i == 3 || i == 11), 12 - i);
            else n_pass++;
            rd_enable = 1'b1;
        end
        @(negedge clk);
        rd_enable = 1'b0;
        n_checks++;
        if ({empty, level} !== {1'b1, CW'(0)})
            $display("FAIL partial_empty: empty=%0b level=%0d exp 1 0", empty, level);
        else n_pass++;
    endtask

    task automatic test_full_overflow();
        for (int e = 0; e < DEPTH; e++) do_write(make_word(100 + 8 * e, 8), 7);
        @(negedge clk);
        n_checks++;
        if ({full, full_n, level, overflow} !== {1'b1, 1'b0, CW'(32), 1'b0})
            $display("FAIL full: full=%0b full_n=%0b level=%0d ovf=%0b exp 1 0 32 0",
                     full, full_n, level, overflow);
        else n_pass++;
        do_write(make_word(500, 8), 7);
        @(negedge clk);
        n_checks++;
        if ({full, level, overflow, data_out} !== {1'b1, CW'(32), 1'b1, OUT_W'(100)})
            $display("FAIL overflow: full=%0b level=%0d ovf=%0b data=%0d exp 1 32 1 100",
                     full, level, overflow, data_out);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({data_out, full} !== {OUT_W'(100 + i), 1'(i < 8)})
                $display("FAIL full_drain[%0d]: data=%0d full=%0b exp data=%0d full=%0b",
                         i, data_out, full, 100 + i, i < 8);
            else n_pass++;
            rd_enable = 1'b1;
        end
        @(negedge clk);
        rd_enable = 1'b0;
        n_checks++;
        if ({empty, level} !== {1'b1, CW'(0)})
            $display("FAIL full_drain_empty: empty=%0b level=%0d exp 1 0", empty, level);
        else n_pass++;
        @(negedge clk);
        rd_enable = 1'b1;
        @(posedge clk);
        #1;
        rd_enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({underflow, overflow, empty, level} !== {1'b1, 1'b1, 1'b1, CW'(0)})
            $display("FAIL underflow: udf=%0b ovf=%0b empty=%0b level=%0d exp 1 1 1 0",
                     underflow, overflow, empty, level);
        else n_pass++;
        pulse_clr();
        @(negedge clk);
        n_checks++;
        if (status !== RESET_STATUS) $display("FAIL clr_flags: got %h exp %h", status, RESET_STATUS);
        else n_pass++;
    endtask

    task automatic test_full_read_write();
        for (int e = 0; e < DEPTH; e++) do_write(make_word(10 * (e + 1), 1), 0);
        @(negedge clk);
        n_checks++;
        if ({full, level} !== {1'b1, CW'(4)})
            $display("FAIL full_single: full=%0b level=%0d exp 1 4", full, level);
        else n_pass++;
        data_in   = make_word(99, 1);
        wr_len    = '0;
        wr_enable = 1'b1;
        rd_enable = 1'b1;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({overflow, full, level, data_out, last} !== {1'b1, 1'b0, CW'(3), OUT_W'(20), 1'b1})
            $display("FAIL full_rw: ovf=%0b full=%0b level=%0d data=%0d last=%0b exp 1 0 3 20 1",
                     overflow, full, level, data_out, last);
        else n_pass++;
        for (int e = 0; e < 3; e++) begin
            if (e > 0) @(negedge clk);
            n_checks++;
            if ({data_out, last} !== {OUT_W'(20 + 10 * e), 1'b1})
                $display("FAIL full_rw_drain[%0d]: data=%0d last=%0b exp %0d 1", e, data_out, last, 20 + 10 * e);
            else n_pass++;
            rd_enable = 1'b1;
        end
        @(negedge clk);
        rd_enable = 1'b0;
        n_checks++;
        if ({empty, level} !== {1'b1, CW'(0)})
            $display("FAIL full_rw_empty: empty=%0b level=%0d exp 1 0", empty, level);
        else n_pass++;
        pulse_clr();
    endtask

    task automatic test_concurrent();
        do_write(make_word(200, 8), 7);
        @(negedge clk);
        n_checks++;
        if (level !== CW'(8)) $display("FAIL conc_pre: level=%0d exp 8", level);
        else n_pass++;
        data_in   = make_word(300, 8);
        wr_len    = LW'(7);
        wr_enable = 1'b1;
        rd_enable = 1'b1;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_checks++;
            if ({data_out, last, level} !==
                {OUT_W'((i < 7) ? 201 + i : 293 + i), 1'(i == 6 || i == 14), CW'(15 - i)})
                $display("FAIL concurrent[%0d]: data=%0d last=%0b level=%0d exp data=%0d last=%0b level=%0d",
                         i, data_out, last, level, (i < 7) ? 201 + i : 293 + i, (i == 6 || i == 14), 15 - i);
            else n_pass++;
            rd_enable = 1'b1;
        end
        @(negedge clk);
        rd_enable = 1'b0;
        n_checks++;
        if ({empty, level} !== {1'b1, CW'(0)})
            $display("FAIL concurrent_empty: empty=%0b level=%0d exp 1 0", empty, level);
        else n_pass++;
    endtask

    task automatic test_clr();
        @(negedge clk);
        rd_enable = 1'b1;
        @(posedge clk);
        #1;
        rd_enable = 1'b0;
        do_write(make_word(400, 8), 7);
        @(negedge clk);
        n_checks++;
        if ({underflow, level, data_out} !== {1'b1, CW'(8), OUT_W'(400)})
            $display("FAIL clr_pre: udf=%0b level=%0d data=%0d exp 1 8 400", underflow, level, data_out);
        else n_pass++;
        clr       = 1'b1;
        data_in   = make_word(600, 8);
        wr_len    = LW'(7);
        wr_enable = 1'b1;
        rd_enable = 1'b1;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (status !== RESET_STATUS) $display("FAIL clr_write: got %h exp %h", status, RESET_STATUS);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (status !== RESET_STATUS) $display("FAIL clr_hold: got %h exp %h", status, RESET_STATUS);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_write(make_word(700, 8), 7);
        do_write(make_word(708, 8), 7);
        @(negedge clk);
        rd_enable = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({data_out, level} !== {OUT_W'(703), CW'(13)})
            $display("FAIL burst_mid: data=%0d level=%0d exp 703 13", data_out, level);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (status !== RESET_STATUS) $display("FAIL async_reset: got %h exp %h", status, RESET_STATUS);
        else n_pass++;
        rd_enable = 1'b0;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (status !== RESET_STATUS) $display("FAIL async_release: got %h exp %h", status, RESET_STATUS);
        else n_pass++;
        do_write(make_word(800, 8), 7);
        @(negedge clk);
        n_checks++;
        if ({data_out, level, empty} !== {OUT_W'(800), CW'(8), 1'b0})
            $display("FAIL post_reset_write: data=%0d level=%0d empty=%0b exp 800 8 0", data_out, level, empty);
        else n_pass++;
    endtask

    initial begin
        clr       = 1'b0;
        data_in   = '0;
        wr_len    = '0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        test_reset();
        test_fill_drain();
        test_partial();
        test_full_overflow();
        test_full_read_write();
        test_concurrent();
        test_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
